// File: rtl/rv32i_fetch_decode_execute_if.sv
// Port bundle of the RV32I fetch/decode/execute block: loader and register-file
// inputs on the master side, decoded control and EX results on the slave side.
interface rv32i_fetch_decode_execute_if;
    logic        imem_we;
    logic [31:0] imem_waddr;
    logic [31:0] imem_wdata;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;

    logic [31:0] pc;
    logic [31:0] instr;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [4:0]  rd_addr;
    logic [31:0] imm;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic [1:0]  wb_sel;
    logic        use_pc_add;
    logic [1:0]  load_size;
    logic [1:0]  store_size;
    logic        load_signed;
    logic [31:0] alu_result;
    logic [31:0] pc_plus4;
    logic [31:0] auipc_result;
    logic [31:0] branch_target;
    logic        branch_taken;
    logic        ecall;
    logic        ebreak;
    logic        fence;
    logic        illegal;

    modport master (
        output imem_we, imem_waddr, imem_wdata, rs1_data, rs2_data,
        input  pc, instr, rs1_addr, rs2_addr, rd_addr, imm,
        input  reg_write, mem_read, mem_write, wb_sel, use_pc_add,
        input  load_size, store_size, load_signed,
        input  alu_result, pc_plus4, auipc_result, branch_target, branch_taken,
        input  ecall, ebreak, fence, illegal
    );

    modport slave (
        input  imem_we, imem_waddr, imem_wdata, rs1_data, rs2_data,
        output pc, instr, rs1_addr, rs2_addr, rd_addr, imm,
        output reg_write, mem_read, mem_write, wb_sel, use_pc_add,
        output load_size, store_size, load_signed,
        output alu_result, pc_plus4, auipc_result, branch_target, branch_taken,
        output ecall, ebreak, fence, illegal
    );
endinterface

// File: rtl/rv32i_fetch_decode_execute.sv
// Single-cycle RV32I IF/ID/EX: PC register, word-addressed instruction memory,
// decoder with immediate generation, ALU and branch/jump resolution.
module rv32i_fetch_decode_execute #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_DEPTH = 1024
) (
    input  logic                          clk,
    input  logic                          rst,
    rv32i_fetch_decode_execute_if.slave   bus
);
    localparam int AW = $clog2(IMEM_DEPTH);

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR,  ALU_AND
    } alu_op_e;

    logic [31:0] mem_q [IMEM_DEPTH];
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr;
    logic [6:0]  opcode, f7;
    logic [2:0]  f3;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm;
    alu_op_e     alu_op;
    logic        b_imm, is_branch, is_jal, is_jalr, br_cond;
    logic        reg_write, mem_read, mem_write, use_pc_add, load_signed;
    logic        ecall, ebreak, fence, illegal;
    logic [1:0]  wb_sel, load_size, store_size;
    logic [31:0] op_b, alu_result, pc_plus4, auipc_result, branch_target;
    logic signed [31:0] rs1_s, rs2_s;
    logic        unused_waddr;

    function automatic alu_op_e func_op(input logic [2:0] fn3, input logic alt);
        case (fn3)
            3'b000:  func_op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  func_op = ALU_SLL;
            3'b010:  func_op = ALU_SLT;
            3'b011:  func_op = ALU_SLTU;
            3'b100:  func_op = ALU_XOR;
            3'b101:  func_op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  func_op = ALU_OR;
            default: func_op = ALU_AND;
        endcase
    endfunction

    function automatic logic [31:0] alu(input alu_op_e op, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa, sb;
        logic [4:0]         sh;
        sa = a;
        sb = b;
        sh = b[4:0];
        case (op)
            ALU_SUB:  alu = a - b;
            ALU_SLL:  alu = a << sh;
            ALU_SLT:  alu = {31'b0, sa < sb};
            ALU_SLTU: alu = {31'b0, a < b};
            ALU_XOR:  alu = a ^ b;
            ALU_SRL:  alu = a >> sh;
            ALU_SRA:  alu = sa >>> sh;
            ALU_OR:   alu = a | b;
            ALU_AND:  alu = a & b;
            default:  alu = a + b;
        endcase
    endfunction

    // IF: loader writes land on the edge, so a same-cycle read sees the old word
    always_ff @(posedge clk) begin
        if (bus.imem_we) mem_q[bus.imem_waddr[AW+1:2]] <= bus.imem_wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) pc_q <= RESET_PC;
        else     pc_q <= pc_d;
    end

    assign instr  = mem_q[pc_q[AW+1:2]];
    assign opcode = instr[6:0];
    assign f3     = instr[14:12];
    assign f7     = instr[31:25];
    assign imm_i  = {{20{instr[31]}}, instr[31:20]};
    assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u  = {instr[31:12], 12'b0};
    assign imm_j  = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    // ID: anything not decoded below leaves every side-effect flag at zero
    always_comb begin
        imm = '0;  alu_op = ALU_ADD;  b_imm = 1'b0;
        is_branch = 1'b0;  is_jal = 1'b0;  is_jalr = 1'b0;
        reg_write = 1'b0;  mem_read = 1'b0;  mem_write = 1'b0;
        wb_sel = 2'b00;  use_pc_add = 1'b0;
        load_size = 2'b00;  store_size = 2'b00;  load_signed = 1'b0;
        ecall = 1'b0;  ebreak = 1'b0;  fence = 1'b0;  illegal = 1'b0;
        case (opcode)
            7'b0110011: begin
                if (f7 == 7'b0000000 || (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101))) begin
                    alu_op = func_op(f3, f7[5]);
                    reg_write = 1'b1;
                end else illegal = 1'b1;
            end
            7'b0010011: begin
                imm = imm_i;  b_imm = 1'b1;
                if ((f3 == 3'b001 && f7 != 7'b0000000) ||
                    (f3 == 3'b101 && f7 != 7'b0000000 && f7 != 7'b0100000)) illegal = 1'b1;
                else begin
                    alu_op = func_op(f3, f3 == 3'b101 && instr[30]);
                    reg_write = 1'b1;
                end
            end
            7'b0000011: begin
                imm = imm_i;  b_imm = 1'b1;
                if (f3 == 3'b011 || f3[2:1] == 2'b11) illegal = 1'b1;
                else begin
                    mem_read = 1'b1;  reg_write = 1'b1;  wb_sel = 2'b01;
                    load_size = f3[1:0];  load_signed = ~f3[2];
                end
            end
            7'b0100011: begin
                imm = imm_s;  b_imm = 1'b1;
                if (f3[2] || f3[1:0] == 2'b11) illegal = 1'b1;
                else begin
                    mem_write = 1'b1;  store_size = f3[1:0];
                end
            end
            7'b1100011: begin
                imm = imm_b;  alu_op = ALU_SUB;
                if (f3[2:1] == 2'b01) illegal = 1'b1;
                else is_branch = 1'b1;
            end
            7'b1101111: begin
                imm = imm_j;  is_jal = 1'b1;  reg_write = 1'b1;  wb_sel = 2'b10;
            end
            7'b1100111: begin
                imm = imm_i;  b_imm = 1'b1;
                if (f3 != 3'b000) illegal = 1'b1;
                else begin
                    is_jalr = 1'b1;  reg_write = 1'b1;  wb_sel = 2'b10;
                end
            end
            7'b0110111: begin
                imm = imm_u;  reg_write = 1'b1;  wb_sel = 2'b11;
            end
            7'b0010111: begin
                imm = imm_u;  reg_write = 1'b1;  use_pc_add = 1'b1;
            end
            7'b0001111: fence = 1'b1;
            7'b1110011: begin
                // CSR forms (funct3 != 0) fall through as a NOP
                if (instr == 32'h0000_0073)      ecall = 1'b1;
                else if (instr == 32'h0010_0073) ebreak = 1'b1;
                else if (f3 == 3'b000)           illegal = 1'b1;
            end
            default: illegal = 1'b1;
        endcase
    end

    // EX
    assign rs1_s        = bus.rs1_data;
    assign rs2_s        = bus.rs2_data;
    assign op_b         = b_imm ? imm : bus.rs2_data;
    assign alu_result   = alu(alu_op, bus.rs1_data, op_b);
    assign pc_plus4     = pc_q + 32'd4;
    assign auipc_result = pc_q + imm;

    always_comb begin
        case (f3)
            3'b000:  br_cond = bus.rs1_data == bus.rs2_data;
            3'b001:  br_cond = bus.rs1_data != bus.rs2_data;
            3'b100:  br_cond = rs1_s < rs2_s;
            3'b101:  br_cond = rs1_s >= rs2_s;
            3'b110:  br_cond = bus.rs1_data < bus.rs2_data;
            default: br_cond = bus.rs1_data >= bus.rs2_data;
        endcase
    end

    assign branch_target = is_jalr ? ((bus.rs1_data + imm) & ~32'h1) : auipc_result;
    assign pc_d          = bus.branch_taken ? branch_target : pc_plus4;
    assign unused_waddr  = ^{bus.imem_waddr[31:AW+2], bus.imem_waddr[1:0]};

    assign bus.pc            = pc_q;
    assign bus.instr         = instr;
    assign bus.rs1_addr      = instr[19:15];
    assign bus.rs2_addr      = instr[24:20];
    assign bus.rd_addr       = instr[11:7];
    assign bus.imm           = imm;
    assign bus.reg_write     = reg_write;
    assign bus.mem_read      = mem_read;
    assign bus.mem_write     = mem_write;
    assign bus.wb_sel        = wb_sel;
    assign bus.use_pc_add    = use_pc_add;
    assign bus.load_size     = load_size;
    assign bus.store_size    = store_size;
    assign bus.load_signed   = load_signed;
    assign bus.alu_result    = alu_result;
    assign bus.pc_plus4      = pc_plus4;
    assign bus.auipc_result  = auipc_result;
    assign bus.branch_target = branch_target;
    assign bus.branch_taken  = is_jal | is_jalr | (is_branch & br_cond);
    assign bus.ecall         = ecall;
    assign bus.ebreak        = ebreak;
    assign bus.fence         = fence;
    assign bus.illegal       = illegal;
endmodule

// File: tb/tb_rv32i_fetch_decode_execute.sv
// Directed bench for rv32i_fetch_decode_execute: per-instruction vector table at
// pc=0 plus hand-written branch/jump, wrap, write-collision and async-reset sequences.
module tb_rv32i_fetch_decode_execute;
    logic clk;
    logic rst;
    int   errors;
    int   checks;

    rv32i_fetch_decode_execute_if bus ();

    rv32i_fetch_decode_execute #(
        .RESET_PC   (32'h0000_0000),
        .IMEM_DEPTH (1024)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [10:0] RW = 11'h400, MR = 11'h200, MW = 11'h100;
    localparam logic [10:0] WB_MEM = 11'h040, WB_PC4 = 11'h080, WB_IMM = 11'h0C0;
    localparam logic [10:0] UPC = 11'h020, TK = 11'h010, ILL = 11'h008;
    localparam logic [10:0] ECL = 11'h004, EBK = 11'h002, FNC = 11'h001;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] alu;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [10:0] ctrl;
        logic [4:0]  sizes;
        logic [31:0] next_pc;
        logic        chk_alu;
        logic        chk_imm;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input logic [31:0] addr, input logic [31:0] data);
        bus.imem_we    = 1'b1;
        bus.imem_waddr = addr;
        bus.imem_wdata = data;
        tick();
        bus.imem_we    = 1'b0;
    endtask

    function automatic logic [10:0] ctrl_now();
        return {bus.reg_write, bus.mem_read, bus.mem_write, bus.wb_sel, bus.use_pc_add,
                bus.branch_taken, bus.illegal, bus.ecall, bus.ebreak, bus.fence};
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        errors = 0;
        checks = 0;
        rst = 1'b1;
        bus.imem_we = 1'b0;
        bus.imem_waddr = '0;
        bus.imem_wdata = '0;
        bus.rs1_data = '0;
        bus.rs2_data = '0;

        //            instr         rs1           rs2           alu           imm           rd  ctrl                 sizes     next          ca ci
        vecs.push_back('{32'h00500093, 32'h0,        32'h0,        32'h5,        32'h5,        1,  RW,                  5'b0,     32'h4,        1, 1});
        vecs.push_back('{32'h4040D193, 32'h80000000, 32'h0,        32'hF8000000, 32'h404,      3,  RW,                  5'b0,     32'h4,        1, 1});
        vecs.push_back('{32'h123452B7, 32'h0,        32'h0,        32'h0,        32'h12345000, 5,  RW | WB_IMM,         5'b0,     32'h4,        0, 1});
        vecs.push_back('{32'h00000000, 32'h0,        32'h0,        32'h0,        32'h0,        0,  ILL,                 5'b0,     32'h4,        0, 0});
        vecs.push_back('{32'h00100073, 32'h0,        32'h0,        32'h0,        32'h0,        0,  EBK,                 5'b0,     32'h4,        0, 0});
        vecs.push_back('{32'h00000073, 32'h0,        32'h0,        32'h0,        32'h0,        0,  ECL,                 5'b0,     32'h4,        0, 0});
        vecs.push_back('{32'h002081B3, 32'hA,        32'hFFFFFFFD, 32'h7,        32'h0,        3,  RW,                  5'b0,     32'h4,        1, 0});
        vecs.push_back('{32'h402081B3, 32'h5,        32'h7,        32'hFFFFFFFE, 32'h0,        3,  RW,                  5'b0,     32'h4,        1, 0});
        vecs.push_back('{32'h0020A233, 32'hFFFFFFFF, 32'h1,        32'h1,        32'h0,        4,  RW,                  5'b0,     32'h4,        1, 0});
        vecs.push_back('{32'h0020B233, 32'hFFFFFFFF, 32'h1,        32'h0,        32'h0,        4,  RW,                  5'b0,     32'h4,        1, 0});
        vecs.push_back('{32'hFFC0A303, 32'h100,      32'h0,        32'hFC,       32'hFFFFFFFC, 6,  RW | MR | WB_MEM,    5'b10001, 32'h4,        1, 1});
        vecs.push_back('{32'h0000C303, 32'h20,       32'h0,        32'h20,       32'h0,        6,  RW | MR | WB_MEM,    5'b00000, 32'h4,        1, 1});
        vecs.push_back('{32'h00209323, 32'h1000,     32'h0,        32'h1006,     32'h6,        6,  MW,                  5'b00010, 32'h4,        1, 1});
        vecs.push_back('{32'hFE209CE3, 32'h3,        32'h4,        32'h0,        32'hFFFFFFF8, 25, TK,                  5'b0,     32'hFFFFFFF8, 0, 1});
        vecs.push_back('{32'h0020E463, 32'hFFFFFFFF, 32'h1,        32'h0,        32'h8,        8,  11'h0,               5'b0,     32'h4,        0, 1});
        vecs.push_back('{32'h0020C463, 32'hFFFFFFFF, 32'h1,        32'h0,        32'h8,        8,  TK,                  5'b0,     32'h8,        0, 1});
        vecs.push_back('{32'h00001397, 32'h0,        32'h0,        32'h0,        32'h1000,     7,  RW | UPC,            5'b0,     32'h4,        0, 1});
        vecs.push_back('{32'h010000EF, 32'h0,        32'h0,        32'h0,        32'h10,       1,  RW | WB_PC4 | TK,    5'b0,     32'h10,       0, 1});
        vecs.push_back('{32'h0000000F, 32'h0,        32'h0,        32'h0,        32'h0,        0,  FNC,                 5'b0,     32'h4,        0, 0});
        vecs.push_back('{32'h00001073, 32'h0,        32'h0,        32'h0,        32'h0,        0,  11'h0,               5'b0,     32'h4,        0, 0});
        vecs.push_back('{32'h00003003, 32'h0,        32'h0,        32'h0,        32'h0,        0,  ILL,                 5'b0,     32'h4,        0, 0});

        #2;
        chk("reset_pc", bus.pc, 32'h0);

        for (int i = 0; i < vecs.size(); i++) begin
            rst = 1'b1;
            #1;
            write_word(32'h0, vecs[i].instr);
            rst = 1'b0;
            bus.rs1_data = vecs[i].rs1;
            bus.rs2_data = vecs[i].rs2;
            #1;
            chk($sformatf("v%0d_instr", i), bus.instr, vecs[i].instr);
            chk($sformatf("v%0d_ctrl", i), {21'b0, ctrl_now()}, {21'b0, vecs[i].ctrl});
            chk($sformatf("v%0d_rd", i), {27'b0, bus.rd_addr}, {27'b0, vecs[i].rd});
            chk($sformatf("v%0d_sizes", i), {27'b0, bus.load_size, bus.store_size, bus.load_signed},
                {27'b0, vecs[i].sizes});
            chk($sformatf("v%0d_pc4", i), bus.pc_plus4, 32'h4);
            if (vecs[i].chk_alu) chk($sformatf("v%0d_alu", i), bus.alu_result, vecs[i].alu);
            if (vecs[i].chk_imm) chk($sformatf("v%0d_imm", i), bus.imm, vecs[i].imm);
            tick();
            chk($sformatf("v%0d_next_pc", i), bus.pc, vecs[i].next_pc);
        end

        // Branch / jump / wrap sequence
        rst = 1'b1;
        #1;
        write_word(32'h000, 32'h00500093);
        write_word(32'h004, 32'h00208463);
        write_word(32'h008, 32'h00000013);
        write_word(32'h00C, 32'h00000013);
        write_word(32'h010, 32'h004080E7);
        write_word(32'h104, 32'h004080E7);
        write_word(32'hFFC, 32'h00000013);
        rst = 1'b0;
        bus.rs1_data = 32'h0;
        bus.rs2_data = 32'h0;
        #1;
        chk("seq_addi_alu", bus.alu_result, 32'h5);
        chk("seq_addi_rd", {27'b0, bus.rd_addr}, 32'h1);
        chk("seq_addi_rw", {31'b0, bus.reg_write}, 32'h1);
        chk("seq_addi_wb", {30'b0, bus.wb_sel}, 32'h0);
        tick();
        chk("seq_pc_after_addi", bus.pc, 32'h4);
        bus.rs1_data = 32'h7;
        bus.rs2_data = 32'h7;
        #1;
        chk("beq_taken", {31'b0, bus.branch_taken}, 32'h1);
        chk("beq_target", bus.branch_target, 32'hC);
        tick();
        chk("beq_pc", bus.pc, 32'hC);

        rst = 1'b1;
        #1;
        chk("async_reset_from_C", bus.pc, 32'h0);
        tick();
        rst = 1'b0;
        bus.rs1_data = 32'h0;
        bus.rs2_data = 32'h0;
        tick();
        chk("seq2_pc4", bus.pc, 32'h4);
        bus.rs1_data = 32'h7;
        bus.rs2_data = 32'h8;
        #1;
        chk("beq_not_taken", {31'b0, bus.branch_taken}, 32'h0);
        tick();
        chk("beq_nt_pc", bus.pc, 32'h8);
        tick();
        tick();
        chk("seq_pc_10", bus.pc, 32'h10);
        bus.rs1_data = 32'h101;
        #1;
        chk("jalr_target", bus.branch_target, 32'h104);
        chk("jalr_pc4", bus.pc_plus4, 32'h14);
        chk("jalr_wb", {30'b0, bus.wb_sel}, 32'h2);
        chk("jalr_taken", {31'b0, bus.branch_taken}, 32'h1);
        tick();
        chk("jalr_pc", bus.pc, 32'h104);
        bus.rs1_data = 32'hFFFFFFF8;
        #1;
        chk("jalr2_target", bus.branch_target, 32'hFFFFFFFC);
        tick();
        chk("wrap_pc", bus.pc, 32'hFFFFFFFC);
        chk("wrap_instr", bus.instr, 32'h00000013);
        chk("wrap_pc4", bus.pc_plus4, 32'h0);
        tick();
        chk("wrap_next_pc", bus.pc, 32'h0);

        // Write collision and mid-cycle reset
        rst = 1'b1;
        #1;
        for (int i = 0; i < 8; i++) write_word(32'(i * 4), 32'h00000013);
        bus.imem_we    = 1'b1;
        bus.imem_waddr = 32'h0;
        bus.imem_wdata = 32'h00000000;
        #1;
        chk("collision_old_word", bus.instr, 32'h00000013);
        @(posedge clk);
        #1;
        bus.imem_we = 1'b0;
        chk("collision_new_word", bus.instr, 32'h00000000);
        write_word(32'h0, 32'h00000013);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        chk("run_to_20", bus.pc, 32'h20);
        #3;
        rst = 1'b1;
        #1;
        chk("midcycle_reset_pc", bus.pc, 32'h0);
        @(posedge clk);
        #1;
        chk("reset_held_pc", bus.pc, 32'h0);
        rst = 1'b0;
        tick();
        chk("post_reset_pc", bus.pc, 32'h4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
